// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single-port data memory between the Control_Unit
// (port C) and the debug/program loader (port G). C normally wins; a C-side lock
// keeps multi-cycle C sequences together, and a wait counter guarantees that a
// starved G request is eventually served. Read data returns one cycle after the
// grant and is steered to whichever port issued the read.
module dmem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              C_REQ,
    input  logic              C_LOCK,
    input  logic              C_WR,
    input  logic [ADDR_W-1:0] C_ADDR,
    input  logic [DATA_W-1:0] C_WDATA,
    output logic              C_GNT,
    output logic              C_RVALID,
    output logic [DATA_W-1:0] C_RDATA,
    input  logic              G_REQ,
    input  logic              G_WR,
    input  logic [ADDR_W-1:0] G_ADDR,
    input  logic [DATA_W-1:0] G_WDATA,
    output logic              G_GNT,
    output logic              G_RVALID,
    output logic [DATA_W-1:0] G_RDATA,
    output logic [ADDR_W-1:0] D_ADDR,
    output logic              D_WR,
    output logic [DATA_W-1:0] D_WDATA,
    input  logic [DATA_W-1:0] D_RDATA
);

    // Which port, if any, owns the read data arriving from memory this cycle.
    typedef enum logic [1:0] {
        TagNone = 2'd0,
        TagC    = 2'd1,
        TagG    = 2'd2
    } rdTag_t;

    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

    logic       lock_q,    lock_d;
    logic [3:0] waitCnt_q, waitCnt_d;
    rdTag_t     rdTag_q,   rdTag_d;

    logic cGnt;
    logic gGnt;

    // Grant decision: lock beats starvation, starvation beats C priority, C beats G.
    always_comb begin
        cGnt = 1'b0;
        gGnt = 1'b0;
        if (Reset) begin
            if (lock_q && C_REQ) begin
                cGnt = 1'b1;
            end else if (G_REQ && (waitCnt_q == MaxWait)) begin
                gGnt = 1'b1;
            end else if (C_REQ) begin
                cGnt = 1'b1;
            end else if (G_REQ) begin
                gGnt = 1'b1;
            end
        end
    end

    assign C_GNT = cGnt;
    assign G_GNT = gGnt;

    // Steer the granted port onto the memory bus; an idle bus is driven to zero.
    always_comb begin
        D_ADDR  = '0;
        D_WR    = 1'b0;
        D_WDATA = '0;
        if (cGnt) begin
            D_ADDR  = C_ADDR;
            D_WR    = C_WR;
            D_WDATA = C_WDATA;
        end else if (gGnt) begin
            D_ADDR  = G_ADDR;
            D_WR    = G_WR;
            D_WDATA = G_WDATA;
        end
    end

    // Next state for the lock, the G starvation counter and the read-return tag.
    always_comb begin
        lock_d    = cGnt & C_LOCK;
        waitCnt_d = waitCnt_q;
        rdTag_d   = TagNone;
        if (gGnt || !G_REQ) begin
            waitCnt_d = 4'd0;
        end else if (waitCnt_q != MaxWait) begin
            waitCnt_d = waitCnt_q + 4'd1;
        end
        if (cGnt && !C_WR) begin
            rdTag_d = TagC;
        end else if (gGnt && !G_WR) begin
            rdTag_d = TagG;
        end
    end

    // State registers with synchronous active-low clear; a pending read is dropped.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            lock_q    <= 1'b0;
            waitCnt_q <= 4'd0;
            rdTag_q   <= TagNone;
        end else begin
            lock_q    <= lock_d;
            waitCnt_q <= waitCnt_d;
            rdTag_q   <= rdTag_d;
        end
    end

    // Read return: only the tagged port sees valid data, the other sees zero.
    // Gating with Reset suppresses a read that was granted just before reset.
    assign C_RVALID = Reset && (rdTag_q == TagC);
    assign G_RVALID = Reset && (rdTag_q == TagG);
    assign C_RDATA  = C_RVALID ? D_RDATA : '0;
    assign G_RDATA  = G_RVALID ? D_RDATA : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: directed scenarios for the data memory port arbiter,
// driving inputs on the falling edge and sampling one time unit later.
module tb_dmem_port_arbiter;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        C_REQ, C_LOCK, C_WR;
    logic [7:0]  C_ADDR;
    logic [15:0] C_WDATA;
    logic        C_GNT, C_RVALID;
    logic [15:0] C_RDATA;
    logic        G_REQ, G_WR;
    logic [7:0]  G_ADDR;
    logic [15:0] G_WDATA;
    logic        G_GNT, G_RVALID;
    logic [15:0] G_RDATA;
    logic [7:0]  D_ADDR;
    logic        D_WR;
    logic [15:0] D_WDATA;
    logic [15:0] D_RDATA;

    logic [15:0] mem [256];

    int compared   = 0;
    int mismatched = 0;

    dmem_port_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_WAIT(4)) dut (
        .Clock(Clock), .Reset(Reset),
        .C_REQ(C_REQ), .C_LOCK(C_LOCK), .C_WR(C_WR), .C_ADDR(C_ADDR), .C_WDATA(C_WDATA),
        .C_GNT(C_GNT), .C_RVALID(C_RVALID), .C_RDATA(C_RDATA),
        .G_REQ(G_REQ), .G_WR(G_WR), .G_ADDR(G_ADDR), .G_WDATA(G_WDATA),
        .G_GNT(G_GNT), .G_RVALID(G_RVALID), .G_RDATA(G_RDATA),
        .D_ADDR(D_ADDR), .D_WR(D_WR), .D_WDATA(D_WDATA), .D_RDATA(D_RDATA)
    );

    always #5 Clock = ~Clock;

    // Synchronous single-port memory: read data valid one cycle after the address.
    always @(posedge Clock) begin
        D_RDATA <= mem[D_ADDR];
        if (D_WR) mem[D_ADDR] <= D_WDATA;
    end

    task automatic idleInputs();
        C_REQ = 0; C_LOCK = 0; C_WR = 0; C_ADDR = 8'h00; C_WDATA = 16'h0000;
        G_REQ = 0; G_WR = 0; G_ADDR = 8'h00; G_WDATA = 16'h0000;
    endtask

    task automatic test_reset();
        idleInputs();
        Reset = 0;
        C_REQ = 1; C_WR = 1; C_ADDR = 8'h77; C_WDATA = 16'h1234;
        G_REQ = 1; G_WR = 1; G_ADDR = 8'h78; G_WDATA = 16'h5678;
        for (int i = 0; i < 2; i++) begin
            @(negedge Clock); #1;
            compared++;
            if (C_GNT !== 1'b0 || G_GNT !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_gnt: got C=%b G=%b expected C=0 G=0", C_GNT, G_GNT);
            end
            compared++;
            if (D_WR !== 1'b0 || D_ADDR !== 8'h00 || D_WDATA !== 16'h0000) begin
                mismatched++;
                $display("[TB] FAIL reset_bus: got wr=%b addr=%h wdata=%h expected 0/00/0000", D_WR, D_ADDR, D_WDATA);
            end
            compared++;
            if (C_RVALID !== 1'b0 || G_RVALID !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL reset_rvalid: got C=%b G=%b expected 0 0", C_RVALID, G_RVALID);
            end
        end
        @(negedge Clock);
        Reset = 1;
        #1;
        compared++;
        if (C_GNT !== 1'b1 || G_GNT !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_release_gnt: got C=%b G=%b expected C=1 G=0", C_GNT, G_GNT);
        end
        compared++;
        if (D_WR !== 1'b1 || D_ADDR !== 8'h77) begin
            mismatched++;
            $display("[TB] FAIL reset_release_bus: got wr=%b addr=%h expected 1/77", D_WR, D_ADDR);
        end
        @(negedge Clock);
        idleInputs();
    endtask

    task automatic test_c_read();
        @(negedge Clock);
        C_REQ = 1; C_WR = 0; C_ADDR = 8'h12;
        #1;
        compared++;
        if (C_GNT !== 1'b1 || D_ADDR !== 8'h12 || D_WR !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL c_read_issue: got gnt=%b addr=%h wr=%b expected 1/12/0", C_GNT, D_ADDR, D_WR);
        end
        @(negedge Clock);
        idleInputs();
        #1;
        compared++;
        if (C_RVALID !== 1'b1 || C_RDATA !== 16'hBEEF) begin
            mismatched++;
            $display("[TB] FAIL c_read_return: got valid=%b data=%h expected 1/beef", C_RVALID, C_RDATA);
        end
        compared++;
        if (G_RVALID !== 1'b0 || G_RDATA !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL c_read_g_quiet: got valid=%b data=%h expected 0/0000", G_RVALID, G_RDATA);
        end
        @(negedge Clock); #1;
        compared++;
        if (C_RVALID !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL c_read_one_cycle: got valid=%b expected 0", C_RVALID);
        end
    endtask

    task automatic test_starvation();
        logic expC [12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] expAddr;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            if (i == 0) begin
                C_REQ = 1; C_WR = 0; C_ADDR = 8'h20;
                G_REQ = 1; G_WR = 0; G_ADDR = 8'h21;
            end
            #1;
            expAddr = expC[i] ? 8'h20 : 8'h21;
            compared++;
            if (C_GNT !== expC[i] || G_GNT !== !expC[i] || D_ADDR !== expAddr) begin
                mismatched++;
                $display("[TB] FAIL starve_cycle%0d: got C=%b G=%b addr=%h expected C=%b G=%b addr=%h",
                         i, C_GNT, G_GNT, D_ADDR, expC[i], !expC[i], expAddr);
            end
        end
        @(negedge Clock);
        idleInputs();
    endtask

    task automatic test_lock();
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock);
            if (i == 0) begin
                C_REQ = 1; C_LOCK = 1; C_WR = 0; C_ADDR = 8'h30;
                G_REQ = 1; G_WR = 0; G_ADDR = 8'h31;
            end
            if (i == 6) C_LOCK = 0;
            #1;
            if (i < 7) begin
                compared++;
                if (C_GNT !== 1'b1 || G_GNT !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL lock_cycle%0d: got C=%b G=%b expected C=1 G=0", i, C_GNT, G_GNT);
                end
            end else begin
                compared++;
                if (C_GNT !== 1'b0 || G_GNT !== 1'b1 || D_ADDR !== 8'h31) begin
                    mismatched++;
                    $display("[TB] FAIL lock_release: got C=%b G=%b addr=%h expected C=0 G=1 addr=31", C_GNT, G_GNT, D_ADDR);
                end
            end
        end
        @(negedge Clock);
        idleInputs();
    endtask

    task automatic test_alternate();
        @(negedge Clock);
        G_REQ = 1; G_WR = 0; G_ADDR = 8'h01;
        #1;
        compared++;
        if (G_GNT !== 1'b1 || D_ADDR !== 8'h01) begin
            mismatched++;
            $display("[TB] FAIL alt_g_issue: got gnt=%b addr=%h expected 1/01", G_GNT, D_ADDR);
        end
        @(negedge Clock);
        idleInputs();
        C_REQ = 1; C_WR = 0; C_ADDR = 8'h02;
        #1;
        compared++;
        if (G_RVALID !== 1'b1 || G_RDATA !== 16'h1111 || C_RVALID !== 1'b0 || C_RDATA !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL alt_g_return: got Gv=%b Gd=%h Cv=%b Cd=%h expected 1/1111/0/0000",
                     G_RVALID, G_RDATA, C_RVALID, C_RDATA);
        end
        @(negedge Clock);
        idleInputs();
        #1;
        compared++;
        if (C_RVALID !== 1'b1 || C_RDATA !== 16'h2222 || G_RVALID !== 1'b0 || G_RDATA !== 16'h0000) begin
            mismatched++;
            $display("[TB] FAIL alt_c_return: got Cv=%b Cd=%h Gv=%b Gd=%h expected 1/2222/0/0000",
                     C_RVALID, C_RDATA, G_RVALID, G_RDATA);
        end
    endtask

    task automatic test_collision();
        @(negedge Clock);
        C_REQ = 1; C_WR = 1; C_ADDR = 8'h50; C_WDATA = 16'hCCCC;
        G_REQ = 1; G_WR = 1; G_ADDR = 8'h50; G_WDATA = 16'h6666;
        #1;
        compared++;
        if (C_GNT !== 1'b1 || G_GNT !== 1'b0 || D_WDATA !== 16'hCCCC || D_WR !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL collide_c_wins: got C=%b G=%b wdata=%h wr=%b expected 1/0/cccc/1", C_GNT, G_GNT, D_WDATA, D_WR);
        end
        @(negedge Clock);
        C_REQ = 0; C_WR = 0;
        #1;
        compared++;
        if (G_GNT !== 1'b1 || D_WDATA !== 16'h6666 || D_WR !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL collide_g_retry: got G=%b wdata=%h wr=%b expected 1/6666/1", G_GNT, D_WDATA, D_WR);
        end
        @(negedge Clock);
        idleInputs();
        G_REQ = 1; G_WR = 0; G_ADDR = 8'h50;
        @(negedge Clock);
        idleInputs();
        #1;
        compared++;
        if (G_RVALID !== 1'b1 || G_RDATA !== 16'h6666) begin
            mismatched++;
            $display("[TB] FAIL collide_final_value: got valid=%b data=%h expected 1/6666", G_RVALID, G_RDATA);
        end
    endtask

    task automatic test_reset_drop();
        @(negedge Clock);
        C_REQ = 1; C_WR = 0; C_ADDR = 8'h12;
        #1;
        compared++;
        if (C_GNT !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL drop_issue: got gnt=%b expected 1", C_GNT);
        end
        @(negedge Clock);
        idleInputs();
        Reset = 0;
        #1;
        compared++;
        if (C_RVALID !== 1'b0 || G_RVALID !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL drop_in_reset: got C=%b G=%b expected 0 0", C_RVALID, G_RVALID);
        end
        @(negedge Clock);
        Reset = 1;
        #1;
        compared++;
        if (C_RVALID !== 1'b0 || G_RVALID !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL drop_after_reset: got C=%b G=%b expected 0 0", C_RVALID, G_RVALID);
        end
        @(negedge Clock);
        G_REQ = 1; G_WR = 1; G_ADDR = 8'h40; G_WDATA = 16'hA5A5;
        #1;
        compared++;
        if (G_GNT !== 1'b1 || D_WR !== 1'b1 || D_ADDR !== 8'h40 || D_WDATA !== 16'hA5A5) begin
            mismatched++;
            $display("[TB] FAIL g_write_issue: got gnt=%b wr=%b addr=%h wdata=%h expected 1/1/40/a5a5",
                     G_GNT, D_WR, D_ADDR, D_WDATA);
        end
        @(negedge Clock);
        idleInputs();
        #1;
        compared++;
        if (D_WR !== 1'b0 || G_RVALID !== 1'b0 || C_RVALID !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL g_write_after: got wr=%b Gv=%b Cv=%b expected 0 0 0", D_WR, G_RVALID, C_RVALID);
        end
        @(negedge Clock);
        G_REQ = 1; G_WR = 0; G_ADDR = 8'h40;
        @(negedge Clock);
        idleInputs();
        #1;
        compared++;
        if (G_RVALID !== 1'b1 || G_RDATA !== 16'hA5A5) begin
            mismatched++;
            $display("[TB] FAIL g_write_readback: got valid=%b data=%h expected 1/a5a5", G_RVALID, G_RDATA);
        end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
        mem[8'h12] = 16'hBEEF;
        mem[8'h01] = 16'h1111;
        mem[8'h02] = 16'h2222;
        Reset = 0;
        idleInputs();
        test_reset();
        test_c_read();
        test_starvation();
        test_lock();
        test_alternate();
        test_collision();
        test_reset_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port 256x16 data memory between two requesters: the Control_Unit (port C) and the debug/program loader (port G).
- Grants at most one access per cycle; the granted port drives the memory address, write enable and write data.
- Returns read data one cycle later and tags it to the port that issued the read.
- Port C has priority. Two mechanisms modify this: a C-side lock that keeps C's grant across back-to-back accesses (e.g. the two-cycle LOAD sequence), and a starvation counter that guarantees G is eventually served.

Parameters:
ADDR_W, 8, data memory address width
DATA_W, 16, data word width
MAX_WAIT, 4, number of consecutive denied G cycles after which G wins over an unlocked C request (range 1..15)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-low reset
C_REQ  in  1  Control_Unit access request
C_LOCK  in  1  keep C grant next cycle if C_REQ stays high
C_WR  in  1  C write (1) / read (0)
C_ADDR  in  ADDR_W  C address
C_WDATA  in  DATA_W  C write data
C_GNT  out  1  C access issued this cycle (combinational)
C_RVALID  out  1  C_RDATA valid (registered)
C_RDATA  out  DATA_W  read data to C
G_REQ  in  1  loader access request
G_WR  in  1  G write/read
G_ADDR  in  ADDR_W  G address
G_WDATA  in  DATA_W  G write data
G_GNT  out  1  G access issued this cycle (combinational)
G_RVALID  out  1  G_RDATA valid (registered)
G_RDATA  out  DATA_W  read data to G
D_ADDR  out  ADDR_W  memory address
D_WR  out  1  memory write enable
D_WDATA  out  DATA_W  memory write data
D_RDATA  in  DATA_W  memory read data, valid one cycle after address

Behaviour:
- Reset (sampled at the rising edge with Reset=0):
  - Clears lock_q, wait_cnt and rd_tag (none pending).
  - While Reset=0: C_GNT=G_GNT=0, D_WR=0, D_ADDR=0, D_WDATA=0, C_RVALID=G_RVALID=0.
  - A read issued in the cycle before reset asserts is dropped; no RVALID follows.
- Registered state:
  - lock_q: C was granted last cycle with C_LOCK=1.
  - wait_cnt: 4 bits, saturating at MAX_WAIT.
  - rd_tag: none / C / G.
- Grant decision, combinational, evaluated in priority order each cycle:
  1. lock_q=1 and C_REQ=1 -> C granted. The lock overrides starvation.
  2. G_REQ=1 and wait_cnt==MAX_WAIT -> G granted.
  3. C_REQ=1 -> C granted.
  4. G_REQ=1 -> G granted.
  5. Otherwise no grant.
- lock_q is released when C_REQ=0, even if C_LOCK was asserted earlier.
- Memory drive:
  - Granted port's ADDR, WR and WDATA go to D_ADDR, D_WR, D_WDATA.
  - With no grant: D_WR=0 and D_ADDR=0.
- Writes complete in the grant cycle and produce no RVALID.
- Read return:
  - A granted read sets rd_tag to the granting port.
  - Next cycle: the tagged port's RVALID=1 for exactly one cycle, and its RDATA=D_RDATA.
  - The other port's RDATA is held at 0.
  - Back-to-back reads give RVALID on consecutive cycles, each tagged correctly, including when C and G alternate.
- Lock update: lock_q <= C_GNT & C_LOCK.
- Wait counter update:
  - Cleared when G_GNT=1 or G_REQ=0.
  - Otherwise incremented, saturating at MAX_WAIT.
  - Counts only cycles in which G requested and was denied.
- Requesters hold REQ, WR, ADDR and WDATA stable until they see GNT. The arbiter has no request queue.
- Simultaneous C and G writes to the same address: only the granted port's write reaches memory. The loser retries.
- MAX_WAIT=0 is unsupported.

Test Plan:
- Reset=0 for 2 cycles with both REQs high -> no GNT, D_WR=0, D_ADDR=0. Reset=1 -> C_GNT=1 in the first cycle.
- C read addr 0x12 (mem=0xBEEF), G idle -> C_GNT same cycle, D_ADDR=0x12; next cycle C_RVALID=1, C_RDATA=0xBEEF, G_RVALID=0.
- C and G request continuously, C_LOCK=0, MAX_WAIT=4 -> C granted 4 cycles, G granted in cycle 5, C in cycle 6; pattern repeats.
- C_LOCK=1 held 6 cycles with G requesting -> C granted all 6 cycles, wait_cnt saturates at 4; C_LOCK drops -> G granted the next cycle.
- Alternating grants: G read 0x01 (0x1111), then C read 0x02 (0x2222) -> G_RVALID with 0x1111, then C_RVALID with 0x2222 on consecutive cycles; no cross-delivery.
- Read granted, then Reset=0 the next cycle -> no RVALID on either port. G write 0x40=0xA5A5 after reset -> D_WR=1 for one cycle, no G_RVALID.
